uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: DATA_BITS, default 8, payload bits per frame (legal 5..8).
REQ-002 Parameter: STOP_BITS, default 1, stop-bit periods per frame (legal 1 or 2).
REQ-003 Port: clk  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: tx_enb  input  1  one-cycle bit-period tick from baud_rate_gen.
REQ-006 Port: req  input  2  level request per requester; index 0 and 1.
REQ-007 Port: data0  input  DATA_BITS  payload of requester 0, sampled on its grant cycle.
REQ-008 Port: data1  input  DATA_BITS  payload of requester 1, sampled on its grant cycle.
REQ-009 Port: gnt  output  2  one-hot, one-cycle acceptance pulse.
REQ-010 Port: tx  output  1  registered serial line, idle high.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, SYNC, START, DATA, STOP.
REQ-013 IDLE with any req high SHALL grant in that cycle: gnt pulses for one cycle, payload latches into the shift register, and the state moves to SYNC; tx_enb is not required.
REQ-014 Arbitration SHALL be round-robin: the requester not granted last has priority; after reset requester 0 has priority.
REQ-015 req SHALL be sampled only in IDLE; requests during SYNC..STOP are held off without gnt.
REQ-016 A requester SHALL drop req in the cycle after its gnt; a still-high req is treated as a new request at the next IDLE.
REQ-017 SYNC: tx=1; on the next tx_enb, tx<=0 and the state moves to START, aligning the start bit to a full bit period.
REQ-018 START: on tx_enb, tx<=bit0 (LSB first) and the state moves to DATA.
REQ-019 DATA: on each tx_enb, shift out the next bit; after DATA_BITS periods, tx<=1 and the state moves to STOP.
REQ-020 STOP: tx=1 for STOP_BITS tx_enb periods; on the final tx_enb, the state moves to IDLE.
REQ-021 Every bit, including start and stop, SHALL last exactly one tx_enb interval.
REQ-022 tx_enb in IDLE SHALL be ignored; tx_enb coincident with a grant SHALL NOT advance SYNC.
REQ-023 The bit counter SHALL be width clog2(DATA_BITS+1) and SHALL never wrap within a frame.
REQ-024 Back-to-back: the final STOP tick leads to IDLE, and a pending req is granted on the following clk; the minimum gap is one SYNC period.
REQ-025 gnt SHALL never be asserted outside IDLE and never have two bits set.

Reset
REQ-026 rst low SHALL immediately force: tx=1, busy=0, gnt=00, state=IDLE, bit counter=0, shift register=0, priority=requester 0.
REQ-027 Reset mid-frame SHALL abort the frame without completing a stop bit; no gnt is issued until rst is high and a req is seen.

Structure
REQ-028 Package uart_pkg SHALL hold the state enumeration and the DATA_BITS/STOP_BITS defaults, shared with the RX side.
REQ-029 Round-robin selection SHALL be a sub-module uart_rr_arb (2-way, priority pointer, one-hot grant).
REQ-030 baud_rate_gen stays external; its tx_enb drives this block's tx_enb.

Verification
REQ-031 Reset: hold rst=0 mid-activity -> tx=1, busy=0, gnt=00 immediately; after release, idle with tx=1.
REQ-032 Single frame: tx_enb every 16 clk; req=01, data0=8'hA5 -> gnt=01 for 1 clk; tx after SYNC = 0,1,0,1,0,0,1,0,1,1, each 16 clk; busy falls after stop.
REQ-033 Contention: after reset, req=11, data0=8'h55, data1=8'h0F -> requester 0 is served first, then 1; with both still high, a third frame goes to requester 0.
REQ-034 Hold-off: req=10 asserted during the DATA of a frame -> no gnt until IDLE; gnt=10 one clk after the final stop tick.
REQ-035 Abort: rst pulsed low during DATA bit 3 -> tx=1 at once; with req=11 afterwards, requester 0 is granted first.
REQ-036 STOP_BITS=2: data0=8'h00 -> tx low for 9 periods, then high for 2 periods before the next start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state enumeration, default frame geometry and
// the two-way round-robin pick used by the transmit arbiter.
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int STOP_BITS_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // One-hot winner of a two-way request; prio set means requester 1 wins ties.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = prio ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant while enabled, priority pointer
// moves to the requester that was not granted.
module uart_rr_arb
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic       prio_r;
  logic [1:0] pick_s;

  // grant decode, only while the transmitter can accept a frame
  always_comb begin
    pick_s = rr_pick(req, prio_r);
    if (en) begin
      gnt = pick_s;
    end else begin
      gnt = 2'b00;
    end
  end

  // priority pointer update on each accepted grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_r <= 1'b0;
    end else if (gnt[0]) begin
      prio_r <= 1'b1;
    end else if (gnt[1]) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// UART transmitter shared by two requesters; frames are aligned to tx_enb ticks
// through a SYNC state so the start bit always lasts a full bit period.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int STOP_BITS = STOP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_enb,
  input  logic [1:0]           req,
  input  logic [DATA_BITS-1:0] data0,
  input  logic [DATA_BITS-1:0] data1,
  output logic [1:0]           gnt,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS + 1);

  uart_state_e          state_r;
  uart_state_e          state_nxt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_nxt_s;
  logic [1:0]           stop_r;
  logic [1:0]           stop_nxt_s;
  logic                 tx_r;
  logic                 tx_nxt_s;
  logic                 busy_r;
  logic                 arb_en_s;
  logic [1:0]           gnt_s;
  logic                 grant_s;
  logic                 last_bit_s;
  logic                 last_stop_s;

  // rst gates the grant so nothing is accepted while reset is held
  assign arb_en_s    = rst && (state_r == ST_IDLE);
  assign grant_s     = |gnt_s;
  assign last_bit_s  = (cnt_r == CW'(DATA_BITS));
  assign last_stop_s = (stop_r == 2'(STOP_BITS));
  assign gnt         = gnt_s;
  assign tx          = tx_r;
  assign busy        = busy_r;

  uart_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (arb_en_s),
    .gnt (gnt_s)
  );

  // frame state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // frame sequencing: every transition past IDLE waits for a bit tick
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  state_nxt_s = grant_s ? ST_SYNC : ST_IDLE;
      ST_SYNC:  state_nxt_s = tx_enb ? ST_START : ST_SYNC;
      ST_START: state_nxt_s = tx_enb ? ST_DATA : ST_START;
      ST_DATA:  state_nxt_s = (tx_enb && last_bit_s) ? ST_STOP : ST_DATA;
      ST_STOP:  state_nxt_s = (tx_enb && last_stop_s) ? ST_IDLE : ST_STOP;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // datapath next values: line level, shifter, bit and stop counters
  always_comb begin
    tx_nxt_s    = tx_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    stop_nxt_s  = stop_r;
    case (state_r)
      ST_IDLE: begin
        tx_nxt_s   = 1'b1;
        cnt_nxt_s  = {CW{1'b0}};
        stop_nxt_s = 2'd0;
        if (grant_s) begin
          shift_nxt_s = gnt_s[1] ? data1 : data0;
        end else begin
          shift_nxt_s = shift_r;
        end
      end
      ST_SYNC: begin
        if (tx_enb) begin
          tx_nxt_s = 1'b0;
        end else begin
          tx_nxt_s = 1'b1;
        end
      end
      ST_START: begin
        if (tx_enb) begin
          tx_nxt_s    = shift_r[0];
          shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
          cnt_nxt_s   = CW'(1);
        end else begin
          tx_nxt_s = tx_r;
        end
      end
      ST_DATA: begin
        if (tx_enb && last_bit_s) begin
          tx_nxt_s   = 1'b1;
          stop_nxt_s = 2'd1;
        end else if (tx_enb) begin
          tx_nxt_s    = shift_r[0];
          shift_nxt_s = {1'b0, shift_r[DATA_BITS-1:1]};
          cnt_nxt_s   = cnt_r + CW'(1);
        end else begin
          tx_nxt_s = tx_r;
        end
      end
      ST_STOP: begin
        tx_nxt_s = 1'b1;
        if (tx_enb && last_stop_s) begin
          stop_nxt_s = 2'd0;
        end else if (tx_enb) begin
          stop_nxt_s = stop_r + 2'd1;
        end else begin
          stop_nxt_s = stop_r;
        end
      end
      default: tx_nxt_s = 1'b1;
    endcase
  end

  // datapath and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_r    <= 1'b1;
      shift_r <= {DATA_BITS{1'b0}};
      cnt_r   <= {CW{1'b0}};
      stop_r  <= 2'd0;
      busy_r  <= 1'b0;
    end else begin
      tx_r    <= tx_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
      stop_r  <= stop_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: table-driven frames, hand-written
// hold-off / abort / two-stop-bit sequences and randomized round-robin traffic.
`timescale 1ns/1ps
module tb_uart_tx_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_enb = 1'b0;
  logic [1:0] req_a = 2'b00, req_b = 2'b00;
  logic [7:0] data0_a = 8'h00, data1_a = 8'h00, data0_b = 8'h00, data1_b = 8'h00;
  logic [1:0] gnt_a, gnt_b;
  logic       tx_a, tx_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail = 0;
  int last_win = -1;

  typedef struct {
    logic       rst_before;
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] exp_gnt;
  } vec_t;
  vec_t vecs[8];

  uart_tx_arb u_dut_a (
    .clk(clk), .rst(rst), .tx_enb(tx_enb), .req(req_a), .data0(data0_a),
    .data1(data1_a), .gnt(gnt_a), .tx(tx_a), .busy(busy_a)
  );

  uart_tx_arb #(.DATA_BITS(8), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .tx_enb(tx_enb), .req(req_b), .data0(data0_b),
    .data1(data1_b), .gnt(gnt_b), .tx(tx_b), .busy(busy_b)
  );

  always #10 clk = ~clk;

  // bit-period tick every 16 clocks, driven away from the active edge
  initial begin
    int baud_cnt;
    baud_cnt = 0;
    forever begin
      @(negedge clk);
      if (baud_cnt == 15) begin
        baud_cnt = 0;
        tx_enb = 1'b1;
      end else begin
        baud_cnt = baud_cnt + 1;
        tx_enb = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h required %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [1:0] gnt_of(input int sel);
    return (sel != 0) ? gnt_b : gnt_a;
  endfunction
  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy_b : busy_a;
  endfunction

  // reference round-robin: requester not granted last wins a tie
  function automatic logic [1:0] model_pick(input logic [1:0] r);
    if (r == 2'b11) return (last_win == 0) ? 2'b10 : 2'b01;
    else return r;
  endfunction

  task automatic wait_tick();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      if (tx_enb) begin
        found = 1'b1;
        break;
      end
    end
    chk("tick_seen", 0, found, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_tx", 0, tx_a, 1);
    chk("rst_busy", 0, busy_a, 0);
    chk("rst_gnt", 0, gnt_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_win = -1;
  endtask

  // waits for a grant, checks it and its one-cycle width, then drops the granted req
  task automatic wait_grant(input int sel, input logic [1:0] exp);
    logic [1:0] g;
    g = 2'b00;
    #1;
    for (int k = 0; k < 40; k++) begin
      g = gnt_of(sel);
      if (g != 2'b00) break;
      @(negedge clk);
      #1;
    end
    chk("gnt", sel, g, exp);
    @(posedge clk);
    #1;
    chk("gnt_pulse", sel, gnt_of(sel), 0);
    if (sel != 0) req_b = req_b & ~g;
    else req_a = req_a & ~g;
    last_win = (g == 2'b10) ? 1 : 0;
  endtask

  // checks the line after every tick of a frame, plus mid-period stability
  task automatic check_frame(input int sel, input logic [7:0] d, input int nstop, input int inject_at);
    int n;
    logic exp_bits[16];
    n = 10 + nstop;
    for (int i = 0; i < n; i++) exp_bits[i] = (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : 1'b1;
    chk("sync_tx", sel, tx_of(sel), 1);
    chk("sync_busy", sel, busy_of(sel), 1);
    for (int i = 0; i < n; i++) begin
      wait_tick();
      #1;
      chk("bit_tx", i, tx_of(sel), exp_bits[i]);
      chk("bit_busy", i, busy_of(sel), (i < n - 1) ? 1 : 0);
      if (i < n - 1) begin
        if (i == inject_at) req_a = 2'b10;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_tx", i, tx_of(sel), exp_bits[i]);
        chk("mid_gnt", i, gnt_of(sel), 0);
      end
    end
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] e;
    vecs[0] = '{1'b1, 2'b01, 8'hA5, 8'h3C, 2'b01};
    vecs[1] = '{1'b1, 2'b11, 8'h55, 8'h0F, 2'b01};
    vecs[2] = '{1'b0, 2'b11, 8'h55, 8'h0F, 2'b10};
    vecs[3] = '{1'b0, 2'b11, 8'h81, 8'h0F, 2'b01};
    vecs[4] = '{1'b0, 2'b10, 8'h00, 8'hC3, 2'b10};
    vecs[5] = '{1'b0, 2'b10, 8'h00, 8'h7E, 2'b10};
    vecs[6] = '{1'b0, 2'b01, 8'hF0, 8'h00, 2'b01};
    vecs[7] = '{1'b0, 2'b11, 8'h12, 8'hED, 2'b10};

    // reset with requests pending: outputs forced, nothing granted
    req_a = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("por_tx", 0, tx_a, 1);
    chk("por_busy", 0, busy_a, 0);
    chk("por_gnt", 0, gnt_a, 0);
    chk("por_gnt_b", 0, gnt_b, 0);
    req_a = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("idle_tx", 0, tx_a, 1);
    chk("idle_busy", 0, busy_a, 0);
    chk("idle_gnt", 0, gnt_a, 0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst_before) begin
        req_a = 2'b00;
        do_reset();
      end
      data0_a = vecs[v].d0;
      data1_a = vecs[v].d1;
      req_a = vecs[v].req;
      wait_grant(0, vecs[v].exp_gnt);
      check_frame(0, (vecs[v].exp_gnt == 2'b10) ? vecs[v].d1 : vecs[v].d0, 1, -1);
    end

    // hold-off: requester 1 raises req during DATA, granted right after the last stop tick
    data0_a = 8'h3C;
    data1_a = 8'hC3;
    req_a = 2'b01;
    wait_grant(0, 2'b01);
    check_frame(0, 8'h3C, 1, 4);
    chk("holdoff_gnt", 0, gnt_a, 2'b10);
    wait_grant(0, 2'b10);
    check_frame(0, 8'hC3, 1, -1);

    // abort during data bit 3; priority returns to requester 0 after reset
    data0_a = 8'h00;
    req_a = 2'b01;
    wait_grant(0, 2'b01);
    repeat (5) wait_tick();
    #1;
    chk("abort_bit3", 0, tx_a, 0);
    repeat (5) @(posedge clk);
    #1;
    req_a = 2'b11;
    rst = 1'b0;
    #1;
    chk("abort_tx", 0, tx_a, 1);
    chk("abort_busy", 0, busy_a, 0);
    chk("abort_gnt", 0, gnt_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_win = -1;
    data0_a = 8'h96;
    data1_a = 8'h69;
    wait_grant(0, 2'b01);
    check_frame(0, 8'h96, 1, -1);

    // randomized traffic against the reference arbiter
    for (int t = 0; t < 12; t++) begin
      r = 2'($urandom_range(1, 3));
      data0_a = 8'($urandom);
      data1_a = 8'($urandom);
      e = model_pick(r);
      req_a = r;
      wait_grant(0, e);
      check_frame(0, (e == 2'b10) ? data1_a : data0_a, 1, -1);
    end
    req_a = 2'b00;

    // two stop bits: nine low periods then two high periods
    data0_b = 8'h00;
    req_b = 2'b01;
    wait_grant(1, 2'b01);
    check_frame(1, 8'h00, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
